dense_neuron_mac: RTL and testbench

DENSE_NEURON_MAC -- requirements
Module: dense_neuron_mac

---
 rtl/nn_pkg.sv | 12 +
 rtl/mac_unit.sv | 31 +++
 rtl/dense_neuron_mac.sv | 82 ++++++++
 tb/tb_dense_neuron_mac.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// nn_pkg: shared constants for the dense neuron datapath.
package nn_pkg;
  localparam int N_INPUTS_DEF = 784;
  localparam int FRAC_BITS_DEF = 16;
  localparam int DATA_W = 32;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_OUT = 2'd3;
  localparam logic signed [63:0] SAT_MAX = 64'sh0000_0000_7FFF_FFFF;
  localparam logic signed [63:0] SAT_MIN = 64'shFFFF_FFFF_8000_0000;
endpackage

// File: rtl/mac_unit.sv
// mac_unit: two-stage signed multiply-accumulate; stage 1 registers operands, stage 2 adds the Q32.32 product.
module mac_unit import nn_pkg::*; #(
  parameter int W = DATA_W
) (
  input  logic                  s_axi_aclk,
  input  logic                  s_axi_aresetn,
  input  logic                  clr,
  input  logic                  hs,
  input  logic [W-1:0]          x,
  input  logic [W-1:0]          w,
  output logic signed [2*W-1:0] acc
);
  logic signed [W-1:0] x_r, w_r;
  logic pv;
  logic signed [2*W-1:0] prod;
  assign prod = (2*W)'(x_r) * (2*W)'(w_r);
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn)
    if (!s_axi_aresetn) begin
      x_r <= '0;
      w_r <= '0;
      pv <= 1'b0;
      acc <= '0;
    end else begin
      if (hs) begin
        x_r <= x;
        w_r <= w;
      end
      pv <= hs;
      acc <= clr ? '0 : pv ? acc + prod : acc;
    end
endmodule

// File: rtl/dense_neuron_mac.sv
// dense_neuron_mac: streams one frame of Q16.16 samples against a weight memory, adds bias, saturates and applies ReLU.
module dense_neuron_mac import nn_pkg::*; #(
  parameter int N_INPUTS = N_INPUTS_DEF,
  parameter int FRAC_BITS = FRAC_BITS_DEF,
  parameter int ADDR_W = 10
) (
  input  logic              s_axi_aclk,
  input  logic              s_axi_aresetn,
  input  logic              start,
  input  logic [31:0]       x_tdata,
  input  logic              x_tvalid,
  output logic              x_tready,
  output logic [ADDR_W-1:0] w_addr,
  input  logic [31:0]       w_data,
  input  logic [31:0]       bias,
  output logic [31:0]       y_tdata,
  output logic              y_tvalid,
  input  logic              y_tready,
  output logic              busy
);
  logic [1:0] state;
  logic start_q, hs, start_edge, last_hs;
  logic [ADDR_W-1:0] cnt;
  logic signed [31:0] bias_r, sat;
  logic signed [63:0] acc, sum, q;
  logic [31:0] y_next;
  assign x_tready = state == S_ACCUM;
  assign busy = state != S_IDLE;
  assign hs = x_tvalid & x_tready;
  assign start_edge = start & ~start_q;
  assign last_hs = hs && cnt == ADDR_W'(N_INPUTS - 1);
  // Look one address ahead on a handshake so w_data always matches the current cnt.
  assign w_addr = hs ? cnt + 1'b1 : cnt;
  assign sum = acc + (64'(bias_r) <<< FRAC_BITS);
  assign q = sum >>> FRAC_BITS;
  assign sat = q > SAT_MAX ? 32'(SAT_MAX) : q < SAT_MIN ? 32'(SAT_MIN) : q[31:0];
  assign y_next = sat[31] ? '0 : sat;
  mac_unit u_mac (
    .s_axi_aclk(s_axi_aclk),
    .s_axi_aresetn(s_axi_aresetn),
    .clr(state == S_IDLE && start_edge),
    .hs(hs),
    .x(x_tdata),
    .w(w_data),
    .acc(acc)
  );
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn)
    if (!s_axi_aresetn) begin
      state <= S_IDLE;
      start_q <= 1'b0;
      cnt <= '0;
      bias_r <= '0;
      y_tdata <= '0;
      y_tvalid <= 1'b0;
    end else begin
      start_q <= start;
      case (state)
        S_IDLE:
          if (start_edge) begin
            state <= S_ACCUM;
            cnt <= '0;
            bias_r <= bias;
          end
        S_ACCUM:
          if (hs) begin
            cnt <= cnt + 1'b1;
            state <= last_hs ? S_DRAIN : S_ACCUM;
          end
        S_DRAIN: state <= S_OUT;
        default:
          // First OUT cycle captures the result; y_tvalid then holds until accepted.
          if (!y_tvalid) begin
            y_tdata <= y_next;
            y_tvalid <= 1'b1;
          end else if (y_tready) begin
            y_tvalid <= 1'b0;
            state <= S_IDLE;
            cnt <= '0;
          end
      endcase
    end
endmodule

// File: tb/tb_dense_neuron_mac.sv
// tb_dense_neuron_mac: scoreboard bench driving a 4-input and a 784-input neuron against an arithmetic reference.
module tb_dense_neuron_mac;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [1:0] start = '0, x_tvalid = '0, y_tready = '0;
  logic [1:0] x_tready, y_tvalid, busy;
  logic [31:0] x_tdata[2], w_data[2], bias[2], y_tdata[2];
  logic [9:0] w_addr[2];
  logic [31:0] wmem[2][1024];
  logic [31:0] xs[784], ws[784];
  logic [31:0] exp_q[2][$];
  int total = 0, bad = 0, cyc = 0;
  int last_hs[2], stall_req[2], stall[2], outs[2];
  logic seen[2];
  logic [31:0] held[2];

  dense_neuron_mac #(.N_INPUTS(4)) u_small (
    .s_axi_aclk(clk), .s_axi_aresetn(rst_n), .start(start[0]),
    .x_tdata(x_tdata[0]), .x_tvalid(x_tvalid[0]), .x_tready(x_tready[0]),
    .w_addr(w_addr[0]), .w_data(w_data[0]), .bias(bias[0]),
    .y_tdata(y_tdata[0]), .y_tvalid(y_tvalid[0]), .y_tready(y_tready[0]), .busy(busy[0])
  );
  dense_neuron_mac u_big (
    .s_axi_aclk(clk), .s_axi_aresetn(rst_n), .start(start[1]),
    .x_tdata(x_tdata[1]), .x_tvalid(x_tvalid[1]), .x_tready(x_tready[1]),
    .w_addr(w_addr[1]), .w_data(w_data[1]), .bias(bias[1]),
    .y_tdata(y_tdata[1]), .y_tvalid(y_tvalid[1]), .y_tready(y_tready[1]), .busy(busy[1])
  );

  always @(posedge clk) begin
    cyc++;
    for (int d = 0; d < 2; d++) w_data[d] <= wmem[d][w_addr[d]];
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_y(input int n, input logic [31:0] b);
    longint acc = 0;
    for (int i = 0; i < n; i++) acc += longint'($signed(xs[i])) * longint'($signed(ws[i]));
    acc += longint'($signed(b)) * 65536;
    acc = acc >>> 16;
    if (acc < 0) return 32'h0;
    if (acc > 64'sh7FFF_FFFF) return 32'h7FFF_FFFF;
    return acc[31:0];
  endfunction

  always @(negedge clk)
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        seen[d] = 1'b0;
        y_tready[d] = 1'b0;
      end else if (y_tvalid[d]) begin
        if (!seen[d]) begin
          seen[d] = 1'b1;
          held[d] = y_tdata[d];
          stall[d] = stall_req[d];
          chk($sformatf("latency%0d", d), cyc - last_hs[d], 3);
          if (exp_q[d].size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_y%0d got=%0h", d, y_tdata[d]);
          end else chk($sformatf("y_tdata%0d", d), y_tdata[d], exp_q[d].pop_front());
          outs[d]++;
        end else chk($sformatf("y_stable%0d", d), y_tdata[d], held[d]);
        y_tready[d] = stall[d] == 0;
        if (stall[d] > 0) stall[d]--;
      end else begin
        seen[d] = 1'b0;
        y_tready[d] = 1'b0;
      end
    end

  task automatic reset_checks();
    for (int e = 0; e < 2; e++) begin
      chk($sformatf("rst_busy%0d", e), busy[e], 0);
      chk($sformatf("rst_x_tready%0d", e), x_tready[e], 0);
      chk($sformatf("rst_y_tvalid%0d", e), y_tvalid[e], 0);
      chk($sformatf("rst_y_tdata%0d", e), y_tdata[e], 0);
      chk($sformatf("rst_w_addr%0d", e), w_addr[e], 0);
    end
  endtask

  task automatic run_frame(input int d, input int n, input logic [31:0] b, input int gap,
                           input int stl, input int pulse_at, input int abort_at);
    int tgt;
    bit ok;
    for (int i = 0; i < n; i++) wmem[d][i] = ws[i];
    @(negedge clk);
    bias[d] = b;
    stall_req[d] = stl;
    start[d] = 1'b1;
    @(negedge clk);
    start[d] = 1'b0;
    for (int i = 0; i < n; i++) begin
      bit done = 0;
      int tries = 0;
      if (i == abort_at) begin
        x_tvalid[d] = 1'b0;
        #1 rst_n = 1'b0;
        #1 reset_checks();
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      while (!done) begin
        x_tvalid[d] = !(gap > 0 && i == 0 && tries == 0) && ($urandom_range(99) >= gap);
        x_tdata[d] = xs[i];
        start[d] = i == pulse_at && tries == 0;
        #1;
        chk($sformatf("x_tready%0d", d), x_tready[d], 1);
        chk($sformatf("w_addr%0d_i%0d", d, i), w_addr[d], x_tvalid[d] ? i + 1 : i);
        done = x_tvalid[d];
        if (done) last_hs[d] = cyc;
        @(negedge clk);
        tries++;
        if (tries > 100) begin
          total++;
          bad++;
          $display("FAIL hs_timeout%0d i=%0d", d, i);
          x_tvalid[d] = 1'b0;
          return;
        end
      end
    end
    x_tvalid[d] = 1'b0;
    start[d] = 1'b0;
    tgt = outs[d] + 1;
    exp_q[d].push_back(ref_y(n, b));
    ok = 0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      #1 ok = outs[d] == tgt && !busy[d];
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL done_timeout%0d outs=%0d want=%0d", d, outs[d], tgt);
    end
  endtask

  task automatic fill(input int n, input logic [31:0] xv, input logic [31:0] wv);
    for (int i = 0; i < n; i++) begin
      xs[i] = xv;
      ws[i] = wv;
    end
  endtask

  task automatic fill_rand(input int n);
    for (int i = 0; i < n; i++) begin
      xs[i] = $urandom;
      ws[i] = $urandom;
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      x_tdata[d] = '0;
      bias[d] = '0;
      outs[d] = 0;
      last_hs[d] = 0;
      stall_req[d] = 0;
      stall[d] = 0;
      seen[d] = 1'b0;
      for (int a = 0; a < 1024; a++) wmem[d][a] = '0;
    end
    repeat (3) @(negedge clk);
    #1 reset_checks();
    rst_n = 1'b1;
    fill(4, 32'h0001_0000, 32'h0002_0000);
    run_frame(0, 4, 32'h0000_8000, 0, 0, -1, -1);
    fill(4, 32'h0001_0000, 32'hFFFF_0000);
    ws[3] = 32'h0;
    run_frame(0, 4, 32'h0001_0000, 0, 0, -1, -1);
    fill(4, 32'h7FFF_0000, 32'h7FFF_0000);
    ws[2] = 32'h0;
    ws[3] = 32'h0;
    run_frame(0, 4, 32'h0, 0, 0, -1, -1);
    fill_rand(4);
    run_frame(0, 4, $urandom, 0, 0, -1, -1);
    run_frame(0, 4, bias[0], 40, 10, -1, -1);
    fill(4, 32'h0001_0000, 32'h0002_0000);
    run_frame(0, 4, 32'h0000_8000, 0, 0, 2, -1);
    fill(784, 32'h7FFF_0000, 32'h7FFF_0000);
    run_frame(1, 784, 32'h0, 0, 0, -1, -1);
    for (int i = 0; i < 784; i++) begin
      xs[i] = $urandom_range(32'h0003_0000) - 32'h0001_8000;
      ws[i] = $urandom_range(32'h0001_0000) - 32'h0000_8000;
    end
    run_frame(1, 784, 32'h0010_0000, 0, 0, -1, 100);
    run_frame(1, 784, 32'h0010_0000, 30, 10, 300, -1);
    fill(4, 32'h0001_0000, 32'h0002_0000);
    run_frame(0, 4, 32'h0000_8000, 0, 0, -1, -1);
    for (int d = 0; d < 2; d++) chk($sformatf("q_empty%0d", d), exp_q[d].size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
